// File: rtl/tmr_scrub_pkg.sv
// tmr_scrub_pkg: shared state type, syndrome codes and address-width helper for the TMR scrubber.
package tmr_scrub_pkg;
  typedef enum logic [2:0] {S_WAIT, S_HOST, S_READ, S_CHECK, S_WRITE} state_t;
  localparam logic [1:0] SYN_NONE = 2'b00;
  localparam logic [1:0] SYN_A = 2'b01;
  localparam logic [1:0] SYN_B = 2'b10;
  localparam logic [1:0] SYN_C = 2'b11;
  function automatic int ADDR_W(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tmr_scrub_voter.sv
// tmr_scrub_voter: bitwise majority vote of three copies, mismatch flag and syndrome of the lowest bad bit.
module tmr_scrub_voter
  import tmr_scrub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] maj,
  output logic             mism,
  output logic [1:0]       syn
);
  assign maj = a & b | b & c | a & c;
  assign mism = |((a ^ b) | (b ^ c));
  // Scan high to low so the lowest mismatching bit has the final say.
  always_comb begin
    syn = SYN_NONE;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (a[i] != b[i] || b[i] != c[i]) syn = (a[i] == b[i]) ? SYN_C : (a[i] == c[i]) ? SYN_B : SYN_A;
  end
endmodule

// File: rtl/tmr_scrub_ctrl.sv
// tmr_scrub_ctrl: background scrubber for a triplicated register bank, yielding the port to the host.
// Optional error log (err_addr/err_syn) is built when TMR_SCRUB_ERR_LOG_EN is defined.
module tmr_scrub_ctrl
  import tmr_scrub_pkg::*;
#(
  parameter int N_WORDS = 16,
  parameter int WIDTH = 16,
  parameter int SCRUB_DIV = 1024,
  parameter int CNT_W = 8,
  localparam int AW = ADDR_W(N_WORDS)
) (
  input  logic             CP,
  input  logic             CDN,
  input  logic             en,
  input  logic             host_req,
  output logic             host_gnt,
  output logic [AW-1:0]    scrub_addr,
  input  logic [WIDTH-1:0] rd_a,
  input  logic [WIDTH-1:0] rd_b,
  input  logic [WIDTH-1:0] rd_c,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy,
  output logic [AW-1:0]    err_addr,
  output logic [1:0]       err_syn
);
  localparam int DIV_W = $clog2(SCRUB_DIV);
  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(SCRUB_DIV - 1);
  localparam logic [AW-1:0] PTR_MAX = AW'(N_WORDS - 1);
  state_t state, nxt;
  logic [DIV_W-1:0] div;
  logic [AW-1:0] ptr;
  logic [WIDTH-1:0] wdat, maj;
  logic mism;
  logic [1:0] syn;
  tmr_scrub_voter #(.WIDTH(WIDTH)) u_voter (.a(rd_a), .b(rd_b), .c(rd_c), .maj(maj), .mism(mism), .syn(syn));
  always_ff @(posedge CP or negedge CDN)
    if (!CDN) state <= S_WAIT;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      S_WAIT: nxt = host_req ? S_HOST : (en && div == '0) ? S_READ : S_WAIT;
      S_HOST: nxt = host_req ? S_HOST : S_WAIT;
      S_READ: nxt = host_req ? S_HOST : S_CHECK;
      S_CHECK: nxt = host_req ? S_HOST : mism ? S_WRITE : S_WAIT;
      S_WRITE: nxt = host_req ? S_HOST : S_WAIT;
      default: nxt = S_WAIT;
    endcase
  end
  always_comb begin
    busy = state inside {S_READ, S_CHECK, S_WRITE};
    host_gnt = state == S_HOST;
    wr_en = state == S_WRITE;
    err_pulse = state == S_WRITE;
    scrub_addr = busy ? ptr : '0;
    wr_data = wr_en ? wdat : '0;
  end
  // Divider runs only in WAIT; a pending host request freezes it.
  always_ff @(posedge CP or negedge CDN)
    if (!CDN) begin
      div <= DIV_INIT;
      ptr <= '0;
      wdat <= '0;
      err_cnt <= '0;
    end else begin
      if (state == S_WAIT && !host_req) div <= (!en || div == '0) ? DIV_INIT : div - 1'b1;
      if (state == S_CHECK) wdat <= maj;
      if ((state == S_CHECK && !host_req && !mism) || state == S_WRITE) ptr <= (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
      if (state == S_WRITE && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
`ifdef TMR_SCRUB_ERR_LOG_EN
  logic [1:0] wsyn;
  always_ff @(posedge CP or negedge CDN)
    if (!CDN) begin
      wsyn <= SYN_NONE;
      err_addr <= '0;
      err_syn <= SYN_NONE;
    end else begin
      if (state == S_CHECK) wsyn <= syn;
      if (state == S_WRITE) begin
        err_addr <= ptr;
        err_syn <= wsyn;
      end
    end
`else
  assign err_addr = '0;
  assign err_syn = SYN_NONE;
`endif
endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// tb_tmr_scrub_ctrl: directed plus randomized bench with a bank model and a cycle-level reference of the scrub rules.
module tb_tmr_scrub_ctrl;
  localparam int N = 4, W = 16, SD = 8, CW = 2;
  logic CP = 0, CDN = 0, en = 0, host_req = 0;
  logic host_gnt, wr_en, err_pulse, busy;
  logic [1:0] scrub_addr, err_addr, err_syn;
  logic [W-1:0] rd_a, rd_b, rd_c, wr_data;
  logic [CW-1:0] err_cnt;
  int vecs = 0, errs = 0, cyc = 0, rel = 0, n = 0, a = 0;
  bit busy_q = 0;
  int rd_t[$], rd_q[$];
  always #5 CP = ~CP;

  tmr_scrub_ctrl #(.N_WORDS(N), .WIDTH(W), .SCRUB_DIV(SD), .CNT_W(CW)) dut (
    .CP(CP), .CDN(CDN), .en(en), .host_req(host_req), .host_gnt(host_gnt), .scrub_addr(scrub_addr),
    .rd_a(rd_a), .rd_b(rd_b), .rd_c(rd_c), .wr_en(wr_en), .wr_data(wr_data), .err_pulse(err_pulse),
    .err_cnt(err_cnt), .busy(busy), .err_addr(err_addr), .err_syn(err_syn));

  // Triplicated bank: registered read, common write, single-bit upset injection.
  logic [W-1:0] bank [3][N] = '{default: '0};
  bit inj = 0;
  int inj_copy = 0, inj_addr = 0, inj_bit = 0;
  always @(posedge CP) begin
    rd_a <= bank[0][scrub_addr];
    rd_b <= bank[1][scrub_addr];
    rd_c <= bank[2][scrub_addr];
    if (wr_en) for (int k = 0; k < 3; k++) bank[k][scrub_addr] = wr_data;
    if (inj) bank[inj_copy][inj_addr][inj_bit] = ~bank[inj_copy][inj_addr][inj_bit];
  end

  function automatic void vote(input logic [W-1:0] x, y, z, output logic [W-1:0] v, output int s);
    s = 0;
    for (int i = 0; i < W; i++) begin
      v[i] = (int'(x[i]) + int'(y[i]) + int'(z[i])) >= 2;
      if (s == 0 && !(x[i] == y[i] && y[i] == z[i])) s = (y[i] == z[i]) ? 1 : (x[i] == z[i]) ? 2 : 3;
    end
  endfunction

  // Reference: m_step 0 idle countdown, 1 address, 2 compare, 3 write-back; m_gnt = host owns the port.
  int m_div = SD - 1, m_step = 0, m_ptr = 0, m_cnt = 0, m_laddr = 0, m_lsyn = 0, m_syn = 0;
  bit m_gnt = 0;
  logic [W-1:0] m_wd = '0;
  always @(posedge CP) begin
    logic [W-1:0] v;
    int s;
    if (!CDN) begin
      m_div = SD - 1; m_step = 0; m_ptr = 0; m_cnt = 0; m_laddr = 0; m_lsyn = 0; m_gnt = 0;
    end else if (m_gnt) m_gnt = host_req;
    else if (m_step == 0) begin
      if (host_req) m_gnt = 1;
      else if (!en) m_div = SD - 1;
      else if (m_div == 0) begin m_div = SD - 1; m_step = 1; end
      else m_div--;
    end else if (m_step == 1) begin
      m_gnt = host_req;
      m_step = host_req ? 0 : 2;
    end else if (m_step == 2) begin
      vote(rd_a, rd_b, rd_c, v, s);
      if (host_req) begin m_gnt = 1; m_step = 0; end
      else if (s != 0) begin m_step = 3; m_wd = v; m_syn = s; end
      else begin m_ptr = (m_ptr + 1) % N; m_step = 0; end
    end else begin
      if (m_cnt < 2 ** CW - 1) m_cnt++;
      m_laddr = m_ptr; m_lsyn = m_syn;
      m_ptr = (m_ptr + 1) % N; m_step = 0; m_gnt = host_req;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit r;
    @(negedge CP);
    cyc++;
    if (busy && !busy_q) begin rd_t.push_back(cyc); rd_q.push_back(int'(scrub_addr)); end
    busy_q = busy;
    r = CDN;
    chk("host_gnt", host_gnt, r && m_gnt);
    chk("busy", busy, r && m_step != 0);
    chk("wr_en", wr_en, r && m_step == 3);
    chk("err_pulse", err_pulse, r && m_step == 3);
    chk("scrub_addr", scrub_addr, (r && m_step != 0) ? m_ptr : 0);
    chk("err_cnt", err_cnt, r ? m_cnt : 0);
    chk("gnt_wr_excl", host_gnt & wr_en, 0);
    if (!r || m_step == 3) chk("wr_data", wr_data, r ? m_wd : 0);
`ifdef TMR_SCRUB_ERR_LOG_EN
    chk("err_addr", err_addr, r ? m_laddr : 0);
    chk("err_syn", err_syn, r ? m_lsyn : 0);
`else
    chk("err_addr", err_addr, 0);
    chk("err_syn", err_syn, 0);
`endif
    #1;
  endtask

  task automatic inject(input int c, input int ad, input int b);
    inj_copy = c; inj_addr = ad; inj_bit = b; inj = 1;
    tick();
    inj = 0;
  endtask

  task automatic wait_reads(input int k);
    for (int i = 0; i < 2000 && rd_t.size() < k; i++) tick();
    chk("read_timeout", rd_t.size() >= k, 1);
  endtask

  task automatic wait_wr();
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (wr_en) break;
    end
    chk("wr_timeout", wr_en, 1);
  endtask

  initial begin
    repeat (3) tick();
    en = 1; CDN = 1; rel = cyc;
    // Clean bank: steady sweep 0,1,2,3,0 every SCRUB_DIV+2 cycles
    wait_reads(5);
    chk("t1_first", rd_t[0] - rel, SD);
    for (int k = 1; k < 5; k++) begin
      chk("t1_gap", rd_t[k] - rd_t[k-1], SD + 2);
      chk("t1_addr", rd_q[k], k % N);
    end
    chk("t1_err_cnt", err_cnt, 0);
    // Copy B bit 0 upset at word 2
    inject(1, 2, 0);
    wait_wr();
    chk("t2_addr", scrub_addr, 2);
    chk("t2_data", wr_data, 16'h0000);
    chk("t2_pulse", err_pulse, 1);
    tick();
    chk("t2_cnt", err_cnt, 1);
`ifdef TMR_SCRUB_ERR_LOG_EN
    chk("t2_err_addr", err_addr, 2);
    chk("t2_err_syn", err_syn, 2'b10);
`endif
    // Host request in a READ cycle aborts, same word rescrubbed
    n = rd_t.size();
    wait_reads(n + 1);
    a = rd_q[n];
    host_req = 1;
    tick();
    chk("t3_gnt", host_gnt, 1);
    chk("t3_no_wr", wr_en, 0);
    repeat (4) tick();
    host_req = 0;
    wait_reads(n + 2);
    chk("t3_rescrub", rd_q[n+1], a);
    // Host request in the WRITE cycle waits for the write
    inject(0, 3, 5);
    wait_wr();
    host_req = 1;
    tick();
    chk("t4_gnt", host_gnt, 1);
    chk("t4_wr", wr_en, 0);
    repeat (2) tick();
    host_req = 0;
    // Saturating counter
    inject(2, 0, 3);
    inject(2, 1, 3);
    inject(2, 2, 3);
    repeat (3) wait_wr();
    tick();
    chk("t5_sat", err_cnt, 3);
    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      tick();
      host_req = host_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) inject($urandom_range(0, 2), $urandom_range(0, N - 1), $urandom_range(0, W - 1));
    end
    host_req = 0; en = 1;
    repeat (20) tick();
    // Asynchronous reset in the middle of a WRITE
    inject(1, 1, 7);
    wait_wr();
    CDN = 0;
    #1;
    chk("t6_wr_en", wr_en, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pulse", err_pulse, 0);
    chk("t6_addr0", scrub_addr, 0);
    chk("t6_cnt", err_cnt, 0);
    chk("t6_data", wr_data, 0);
    tick(); tick();
    CDN = 1; rel = cyc;
    n = rd_t.size();
    wait_reads(n + 1);
    chk("t6_restart_addr", rd_q[n], 0);
    chk("t6_restart_t", rd_t[n] - rel, SD);
    repeat (40) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
